// File: rtl/memory_stage_cache_if.sv
// rtl/memory_stage_cache_if.sv - RISC-V MEM stage: L1 cache handshake, load/store formatting, MEM/WB register
//
// Purpose:
//   Memory stage of a 5-stage RISC-V pipeline. Aligned loads/stores from EX/MEM
//   are sent to the L1 cache controller with a valid/ready request channel.
//   The stage then waits for a single-cycle valid response, stalling the
//   pipeline until that response arrives. Load data is sign/zero extended
//   according to funct3. Store data is replicated across byte lanes with
//   matching strobes. The MEM/WB pipeline register is held here. A wait
//   timeout aborts a transaction that never completes.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   RegwriteM .. pc_plus4M   EX/MEM pipeline register contents
//   cache_req_*              request channel to L1 (valid/ready, we, addr, wdata, wstrb)
//   cache_resp_*             response channel from L1 (valid, aligned read word)
//   stall_m                  hold request to the hazard unit
//   misalign_err             one-cycle pulse when a misaligned access is dropped
//   timeout_err              sticky abort flag, cleared only by reset
//   RegwriteW .. pc_plus4W   MEM/WB pipeline register outputs

module memory_stage_cache_if #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegwriteM,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [2:0]  funct3M,
  input  logic [4:0]  RdM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] pc_plus4M,
  output logic        cache_req_valid,
  input  logic        cache_req_ready,
  output logic        cache_req_we,
  output logic [31:0] cache_req_addr,
  output logic [31:0] cache_req_wdata,
  output logic [3:0]  cache_req_wstrb,
  input  logic        cache_resp_valid,
  input  logic [31:0] cache_resp_rdata,
  output logic        stall_m,
  output logic        misalign_err,
  output logic        timeout_err,
  output logic        RegwriteW,
  output logic [1:0]  ResultSrcW,
  output logic [4:0]  RdW,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] pc_plus4W
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

  logic [0:0]       state;
  logic [CNT_W-1:0] waitCnt;
  logic             timeoutErrQ;

  logic        memOp;
  logic        sizeHalf;
  logic        sizeWord;
  logic        badFunct3;
  logic        misaligned;
  logic        alignedOp;
  logic [1:0]  byteOff;
  logic        halfOff;
  logic        inIdle;
  logic        inWait;
  logic        reqAccept;
  logic        respTake;
  logic        timeoutHit;
  logic [7:0]  byteSel;
  logic [15:0] halfSel;
  logic [31:0] loadData;
  logic        takeM;
  logic        regwriteNext;
  logic [31:0] readDataNext;

  // ---------------------------------------------------------------------------
  // Access classification
  // ---------------------------------------------------------------------------
  assign byteOff  = ALUResultM[1:0];
  assign halfOff  = ALUResultM[1];
  assign memOp    = MemReadM | MemWriteM;
  assign sizeHalf = (funct3M[1:0] == 2'b01);
  assign sizeWord = (funct3M[1:0] == 2'b10);

  // Stores only have SB/SH/SW; loads additionally have LBU/LHU.
  always_comb begin
    badFunct3 = 1'b0;
    if (MemWriteM) begin
      badFunct3 = funct3M[2] | (funct3M[1:0] == 2'b11);
    end else begin
      badFunct3 = (funct3M == 3'b011) | (funct3M[2:1] == 2'b11);
    end
  end

  assign misaligned = memOp & (badFunct3
                             | (sizeHalf & byteOff[0])
                             | (sizeWord & (byteOff != 2'b00)));
  assign alignedOp  = memOp & ~misaligned;

  // ---------------------------------------------------------------------------
  // Handshake and stall. Everything visible to the pipe is masked during
  // reset so that upstream never sees a request from a stale state.
  // ---------------------------------------------------------------------------
  assign inIdle = rst & (state == ST_IDLE);
  assign inWait = rst & (state == ST_WAIT);

  assign cache_req_valid = inIdle & alignedOp;
  assign reqAccept       = cache_req_valid & cache_req_ready;

  // A response is only meaningful once the request has been accepted; one
  // arriving in IDLE is a leftover from an aborted transaction.
  assign respTake   = inWait & cache_resp_valid;
  assign timeoutHit = inWait & ~cache_resp_valid & (waitCnt == TIMEOUT_VAL);

  assign stall_m      = (inIdle & alignedOp) | (inWait & ~cache_resp_valid & ~timeoutHit);
  assign misalign_err = inIdle & misaligned;
  assign timeout_err  = timeoutErrQ | timeoutHit;

  // ---------------------------------------------------------------------------
  // Request fields, driven straight from EX/MEM (held stable during a stall)
  // ---------------------------------------------------------------------------
  assign cache_req_we   = MemWriteM;
  assign cache_req_addr = {ALUResultM[31:2], 2'b00};

  always_comb begin
    cache_req_wdata = 32'h0;
    cache_req_wstrb = 4'b0000;
    if (MemWriteM) begin
      case (funct3M[1:0])
        2'b00: begin
          cache_req_wdata = {4{WriteDataM[7:0]}};
          cache_req_wstrb = 4'b0001 << byteOff;
        end
        2'b01: begin
          cache_req_wdata = {2{WriteDataM[15:0]}};
          cache_req_wstrb = halfOff ? 4'b1100 : 4'b0011;
        end
        default: begin
          cache_req_wdata = WriteDataM;
          cache_req_wstrb = 4'b1111;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Load data formatting
  // ---------------------------------------------------------------------------
  always_comb begin
    byteSel = 8'h00;
    case (byteOff)
      2'b00:   byteSel = cache_resp_rdata[7:0];
      2'b01:   byteSel = cache_resp_rdata[15:8];
      2'b10:   byteSel = cache_resp_rdata[23:16];
      default: byteSel = cache_resp_rdata[31:24];
    endcase
  end

  assign halfSel = halfOff ? cache_resp_rdata[31:16] : cache_resp_rdata[15:0];

  always_comb begin
    loadData = cache_resp_rdata;
    case (funct3M)
      3'b000:  loadData = {{24{byteSel[7]}}, byteSel};
      3'b100:  loadData = {24'h0, byteSel};
      3'b001:  loadData = {{16{halfSel[15]}}, halfSel};
      3'b101:  loadData = {16'h0, halfSel};
      default: loadData = cache_resp_rdata;
    endcase
  end

  // ---------------------------------------------------------------------------
  // MEM/WB next-value selection. takeM passes the M fields through; otherwise
  // the register is loaded with an all-zero bubble.
  // ---------------------------------------------------------------------------
  always_comb begin
    takeM        = 1'b0;
    regwriteNext = 1'b0;
    readDataNext = 32'h0;
    if (state == ST_IDLE) begin
      if (!memOp) begin
        takeM        = 1'b1;
        regwriteNext = RegwriteM;
      end else if (misaligned) begin
        // Dropped access still advances, but must not write the register file.
        takeM = 1'b1;
      end
    end else begin
      if (cache_resp_valid) begin
        takeM        = 1'b1;
        regwriteNext = RegwriteM;
        readDataNext = MemReadM ? loadData : 32'h0;
      end else if (timeoutHit) begin
        takeM = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      waitCnt     <= '0;
      timeoutErrQ <= 1'b0;
      RegwriteW   <= 1'b0;
      ResultSrcW  <= 2'b00;
      RdW         <= 5'd0;
      ALUResultW  <= 32'h0;
      ReadDataW   <= 32'h0;
      pc_plus4W   <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (reqAccept) begin
            state   <= ST_WAIT;
            waitCnt <= '0;
          end
        end
        default: begin
          if (respTake || timeoutHit) begin
            state <= ST_IDLE;
          end else begin
            waitCnt <= waitCnt + CNT_W'(1);
          end
        end
      endcase

      if (timeoutHit) begin
        timeoutErrQ <= 1'b1;
      end

      RegwriteW  <= regwriteNext;
      ResultSrcW <= takeM ? ResultSrcM : 2'b00;
      RdW        <= takeM ? RdM : 5'd0;
      ALUResultW <= takeM ? ALUResultM : 32'h0;
      pc_plus4W  <= takeM ? pc_plus4M : 32'h0;
      ReadDataW  <= readDataNext;
    end
  end

endmodule

// File: tb/tb_memory_stage_cache_if.sv
// tb/tb_memory_stage_cache_if.sv - directed self-checking bench for memory_stage_cache_if
module tb_memory_stage_cache_if;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegwriteM, MemReadM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  funct3M;
  logic [4:0]  RdM;
  logic [31:0] ALUResultM, WriteDataM, pc_plus4M;
  logic        cache_req_valid, cache_req_ready, cache_req_we;
  logic [31:0] cache_req_addr, cache_req_wdata;
  logic [3:0]  cache_req_wstrb;
  logic        cache_resp_valid;
  logic [31:0] cache_resp_rdata;
  logic        stall_m, misalign_err, timeout_err;
  logic        RegwriteW;
  logic [1:0]  ResultSrcW;
  logic [4:0]  RdW;
  logic [31:0] ALUResultW, ReadDataW, pc_plus4W;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  memory_stage_cache_if #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .RegwriteM(RegwriteM), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .ResultSrcM(ResultSrcM), .funct3M(funct3M), .RdM(RdM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .pc_plus4M(pc_plus4M),
    .cache_req_valid(cache_req_valid), .cache_req_ready(cache_req_ready),
    .cache_req_we(cache_req_we), .cache_req_addr(cache_req_addr),
    .cache_req_wdata(cache_req_wdata), .cache_req_wstrb(cache_req_wstrb),
    .cache_resp_valid(cache_resp_valid), .cache_resp_rdata(cache_resp_rdata),
    .stall_m(stall_m), .misalign_err(misalign_err), .timeout_err(timeout_err),
    .RegwriteW(RegwriteW), .ResultSrcW(ResultSrcW), .RdW(RdW),
    .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .pc_plus4W(pc_plus4W)
  );

  // Load-format vectors: funct3, address, rdata, expected ReadDataW
  logic [2:0]  lfF3   [6] = '{3'b000, 3'b100, 3'b001, 3'b001, 3'b010, 3'b000};
  logic [31:0] lfAddr [6] = '{32'h101, 32'h102, 32'h402, 32'h400, 32'h404, 32'h100};
  logic [31:0] lfData [6] = '{32'h1122_7F33, 32'h11A2_3344, 32'h9ABC_0000,
                              32'h0000_7FFF, 32'hDEAD_BEEF, 32'h0000_00F0};
  logic [31:0] lfExp  [6] = '{32'h0000_007F, 32'h0000_00A2, 32'hFFFF_9ABC,
                              32'h0000_7FFF, 32'hDEAD_BEEF, 32'hFFFF_FFF0};

  // Store vectors: funct3, address, WriteDataM, expected wstrb, expected wdata
  logic [2:0]  stF3   [4] = '{3'b000, 3'b000, 3'b001, 3'b010};
  logic [31:0] stAddr [4] = '{32'h301, 32'h303, 32'h300, 32'h304};
  logic [31:0] stWd   [4] = '{32'hCAFE_005A, 32'h0000_00C3, 32'h89AB_4567, 32'h0123_4567};
  logic [3:0]  stStrb [4] = '{4'b0010, 4'b1000, 4'b0011, 4'b1111};
  logic [31:0] stExp  [4] = '{32'h5A5A_5A5A, 32'hC3C3_C3C3, 32'h4567_4567, 32'h0123_4567};

  // Misalign vectors: read, write, funct3, address
  logic        maRd   [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  logic        maWr   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic [2:0]  maF3   [4] = '{3'b010, 3'b001, 3'b100, 3'b011};
  logic [31:0] maAddr [4] = '{32'h6, 32'h11, 32'h20, 32'h20};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearM();
    RegwriteM = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b0;
    ResultSrcM = 2'b00; funct3M = 3'b000; RdM = 5'd0;
    ALUResultM = 32'h0; WriteDataM = 32'h0; pc_plus4M = 32'h0;
    cache_req_ready = 1'b0; cache_resp_valid = 1'b0; cache_resp_rdata = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clearM();
    MemReadM = 1'b1; funct3M = 3'b010; ALUResultM = 32'h40; RegwriteM = 1'b1;
    ResultSrcM = 2'b01; RdM = 5'd3; pc_plus4M = 32'h44; cache_req_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      vecs++;
      if ({cache_req_valid, stall_m, misalign_err} !== 3'b000) begin
        errs++;
        $display("FAIL reset_outputs cyc%0d: valid/stall/misalign=%b required 000", i,
                 {cache_req_valid, stall_m, misalign_err});
      end
      step();
      vecs++;
      if ({RegwriteW, ResultSrcW, RdW, ALUResultW, ReadDataW, pc_plus4W, timeout_err} !== '0) begin
        errs++;
        $display("FAIL reset_wreg cyc%0d: Rw=%b Rs=%b Rd=%0d alu=%h rd=%h pc=%h to=%b required all 0", i,
                 RegwriteW, ResultSrcW, RdW, ALUResultW, ReadDataW, pc_plus4W, timeout_err);
      end
    end
    rst = 1'b1;
    cache_req_ready = 1'b0;
    #1;
    vecs++;
    if ({cache_req_valid, stall_m} !== 2'b11) begin
      errs++;
      $display("FAIL reset_release: valid/stall=%b required 11", {cache_req_valid, stall_m});
    end
    clearM();
    step();
  endtask

  task automatic test_lb();
    clearM();
    MemReadM = 1'b1; funct3M = 3'b000; ALUResultM = 32'h103; RegwriteM = 1'b1;
    ResultSrcM = 2'b01; RdM = 5'd7; pc_plus4M = 32'h2004;
    cache_resp_rdata = 32'h80AA_BBCC; cache_req_ready = 1'b1;
    #1;
    vecs++;
    if ({cache_req_valid, stall_m, cache_req_we, cache_req_wstrb} !== 7'b1100000 ||
        cache_req_addr !== 32'h100) begin
      errs++;
      $display("FAIL lb_req: v/s/we/strb=%b addr=%h required 1100000 addr=00000100",
               {cache_req_valid, stall_m, cache_req_we, cache_req_wstrb}, cache_req_addr);
    end
    step();
    vecs++;
    if (RegwriteW !== 1'b0 || ReadDataW !== 32'h0) begin
      errs++;
      $display("FAIL lb_bubble: Rw=%b rd=%h required 0 0", RegwriteW, ReadDataW);
    end
    cache_req_ready = 1'b0; cache_resp_valid = 1'b1;
    #1;
    vecs++;
    if ({cache_req_valid, stall_m} !== 2'b00) begin
      errs++;
      $display("FAIL lb_resp_cycle: valid/stall=%b required 00", {cache_req_valid, stall_m});
    end
    step();
    vecs++;
    if (RegwriteW !== 1'b1 || ReadDataW !== 32'hFFFF_FF80 || RdW !== 5'd7 ||
        ResultSrcW !== 2'b01 || ALUResultW !== 32'h103 || pc_plus4W !== 32'h2004) begin
      errs++;
      $display("FAIL lb_wb: Rw=%b rd=%h Rd=%0d Rs=%b alu=%h pc=%h required 1 ffffff80 7 01 00000103 00002004",
               RegwriteW, ReadDataW, RdW, ResultSrcW, ALUResultW, pc_plus4W);
    end
    clearM();
    #1;
    vecs++;
    if (stall_m !== 1'b0) begin
      errs++;
      $display("FAIL lb_after_stall: stall=%b required 0", stall_m);
    end
    step();
    vecs++;
    if (RegwriteW !== 1'b0) begin
      errs++;
      $display("FAIL lb_regwrite_one_cycle: Rw=%b required 0", RegwriteW);
    end
  endtask

  task automatic test_sh();
    clearM();
    MemWriteM = 1'b1; funct3M = 3'b001; ALUResultM = 32'h202; WriteDataM = 32'h1234_ABCD;
    cache_req_ready = 1'b1;
    #1;
    vecs++;
    if ({cache_req_valid, cache_req_we, cache_req_wstrb} !== 6'b111100 ||
        cache_req_addr !== 32'h200 || cache_req_wdata !== 32'hABCD_ABCD) begin
      errs++;
      $display("FAIL sh_req: v/we/strb=%b addr=%h wdata=%h required 111100 00000200 abcdabcd",
               {cache_req_valid, cache_req_we, cache_req_wstrb}, cache_req_addr, cache_req_wdata);
    end
    step();
    cache_req_ready = 1'b0; cache_resp_valid = 1'b1; cache_resp_rdata = 32'h5555_5555;
    #1;
    vecs++;
    if (stall_m !== 1'b0) begin
      errs++;
      $display("FAIL sh_ack_stall: stall=%b required 0", stall_m);
    end
    step();
    vecs++;
    if (RegwriteW !== 1'b0 || ReadDataW !== 32'h0 || ALUResultW !== 32'h202) begin
      errs++;
      $display("FAIL sh_wb: Rw=%b rd=%h alu=%h required 0 00000000 00000202", RegwriteW, ReadDataW, ALUResultW);
    end
    clearM();
    step();
  endtask

  task automatic test_misalign();
    for (int i = 0; i < 4; i++) begin
      clearM();
      MemReadM = maRd[i]; MemWriteM = maWr[i]; funct3M = maF3[i]; ALUResultM = maAddr[i];
      RegwriteM = 1'b1; RdM = 5'd12;
      #1;
      vecs++;
      if ({misalign_err, cache_req_valid, stall_m} !== 3'b100) begin
        errs++;
        $display("FAIL misalign_%0d: err/valid/stall=%b required 100", i,
                 {misalign_err, cache_req_valid, stall_m});
      end
      step();
      vecs++;
      if (RegwriteW !== 1'b0 || ALUResultW !== maAddr[i] || RdW !== 5'd12) begin
        errs++;
        $display("FAIL misalign_wb_%0d: Rw=%b alu=%h Rd=%0d required 0 %h 12", i,
                 RegwriteW, ALUResultW, RdW, maAddr[i]);
      end
      clearM();
      for (int k = 0; k < 2; k++) begin
        #1;
        vecs++;
        if ({misalign_err, cache_req_valid, stall_m} !== 3'b000) begin
          errs++;
          $display("FAIL misalign_pulse_%0d_%0d: err/valid/stall=%b required 000", i, k,
                   {misalign_err, cache_req_valid, stall_m});
        end
        step();
      end
    end
  endtask

  task automatic test_lhu_slow();
    int stallCnt;
    stallCnt = 0;
    clearM();
    MemReadM = 1'b1; funct3M = 3'b101; ALUResultM = 32'h10; RegwriteM = 1'b1;
    ResultSrcM = 2'b01; RdM = 5'd9; pc_plus4M = 32'h3008; cache_resp_rdata = 32'hF00D_8001;
    for (int i = 0; i < 6; i++) begin
      cache_req_ready = (i == 3);
      #1;
      if (stall_m === 1'b1) stallCnt++;
      vecs++;
      if (cache_req_valid !== (i <= 3)) begin
        errs++;
        $display("FAIL lhu_valid_%0d: valid=%b required %b", i, cache_req_valid, (i <= 3));
      end
      step();
      vecs++;
      if (RegwriteW !== 1'b0 || ALUResultW !== 32'h0 || RdW !== 5'd0) begin
        errs++;
        $display("FAIL lhu_bubble_%0d: Rw=%b alu=%h Rd=%0d required 0 0 0", i, RegwriteW, ALUResultW, RdW);
      end
    end
    cache_req_ready = 1'b0; cache_resp_valid = 1'b1;
    #1;
    if (stall_m === 1'b1) stallCnt++;
    step();
    vecs++;
    if (stallCnt !== 6) begin
      errs++;
      $display("FAIL lhu_stall_cycles: got %0d required 6", stallCnt);
    end
    vecs++;
    if (RegwriteW !== 1'b1 || ReadDataW !== 32'h0000_8001 || RdW !== 5'd9) begin
      errs++;
      $display("FAIL lhu_wb: Rw=%b rd=%h Rd=%0d required 1 00008001 9", RegwriteW, ReadDataW, RdW);
    end
    clearM();
    step();
  endtask

  task automatic test_load_format();
    for (int i = 0; i < 6; i++) begin
      clearM();
      MemReadM = 1'b1; funct3M = lfF3[i]; ALUResultM = lfAddr[i]; RegwriteM = 1'b1;
      RdM = 5'd20; cache_resp_rdata = lfData[i];
      cache_req_ready = 1'b1; cache_resp_valid = 1'b1;   // response in the accept cycle must be ignored
      #1;
      vecs++;
      if (stall_m !== 1'b1) begin
        errs++;
        $display("FAIL lf_accept_stall_%0d: stall=%b required 1", i, stall_m);
      end
      step();
      vecs++;
      if (RegwriteW !== 1'b0) begin
        errs++;
        $display("FAIL lf_early_resp_%0d: Rw=%b required 0", i, RegwriteW);
      end
      cache_req_ready = 1'b0;
      #1;
      step();
      vecs++;
      if (RegwriteW !== 1'b1 || ReadDataW !== lfExp[i]) begin
        errs++;
        $display("FAIL lf_data_%0d: Rw=%b rd=%h required 1 %h", i, RegwriteW, ReadDataW, lfExp[i]);
      end
    end
    clearM();
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      clearM();
      MemWriteM = 1'b1; funct3M = stF3[i]; ALUResultM = stAddr[i]; WriteDataM = stWd[i];
      cache_req_ready = 1'b1;
      #1;
      vecs++;
      if (cache_req_valid !== 1'b1 || cache_req_we !== 1'b1 || cache_req_wstrb !== stStrb[i] ||
          cache_req_wdata !== stExp[i] || cache_req_addr !== {stAddr[i][31:2], 2'b00}) begin
        errs++;
        $display("FAIL b2b_req_%0d: v=%b we=%b strb=%b wdata=%h addr=%h required 1 1 %b %h %h", i,
                 cache_req_valid, cache_req_we, cache_req_wstrb, cache_req_wdata, cache_req_addr,
                 stStrb[i], stExp[i], {stAddr[i][31:2], 2'b00});
      end
      step();
      cache_req_ready = 1'b0; cache_resp_valid = 1'b1;
      #1;
      vecs++;
      if ({cache_req_valid, stall_m} !== 2'b00) begin
        errs++;
        $display("FAIL b2b_wait_%0d: valid/stall=%b required 00", i, {cache_req_valid, stall_m});
      end
      step();
      vecs++;
      if (ReadDataW !== 32'h0 || ALUResultW !== stAddr[i]) begin
        errs++;
        $display("FAIL b2b_wb_%0d: rd=%h alu=%h required 0 %h", i, ReadDataW, ALUResultW, stAddr[i]);
      end
    end
    clearM();
    step();
  endtask

  task automatic test_timeout();
    int  waitStall;
    logic released;
    waitStall = 0;
    released  = 1'b0;
    clearM();
    MemReadM = 1'b1; funct3M = 3'b010; ALUResultM = 32'h20; RegwriteM = 1'b1;
    ResultSrcM = 2'b01; RdM = 5'd4; pc_plus4M = 32'h104; cache_resp_rdata = 32'hFFFF_FFFF;
    cache_req_ready = 1'b1;
    #1;
    vecs++;
    if ({stall_m, timeout_err} !== 2'b10) begin
      errs++;
      $display("FAIL to_accept: stall/to=%b required 10", {stall_m, timeout_err});
    end
    step();
    cache_req_ready = 1'b0;
    for (int i = 0; i < 10 && !released; i++) begin
      #1;
      if (stall_m === 1'b1) begin
        waitStall++;
        step();
      end else begin
        released = 1'b1;
      end
    end
    vecs++;
    if (!released) begin
      errs++;
      $display("FAIL to_bound: stall never released within 10 cycles, required release");
    end
    vecs++;
    if (waitStall !== 4) begin
      errs++;
      $display("FAIL to_wait_cycles: got %0d required 4", waitStall);
    end
    vecs++;
    if (timeout_err !== 1'b1) begin
      errs++;
      $display("FAIL to_flag: to=%b required 1", timeout_err);
    end
    step();
    vecs++;
    if (RegwriteW !== 1'b0 || ReadDataW !== 32'h0 || ALUResultW !== 32'h20 || RdW !== 5'd4 ||
        timeout_err !== 1'b1) begin
      errs++;
      $display("FAIL to_wb: Rw=%b rd=%h alu=%h Rd=%0d to=%b required 0 0 00000020 4 1",
               RegwriteW, ReadDataW, ALUResultW, RdW, timeout_err);
    end
    clearM();
    cache_resp_valid = 1'b1; cache_resp_rdata = 32'h1234_5678;
    #1;
    vecs++;
    if ({stall_m, cache_req_valid} !== 2'b00) begin
      errs++;
      $display("FAIL to_late_resp: stall/valid=%b required 00", {stall_m, cache_req_valid});
    end
    step();
    vecs++;
    if (ReadDataW !== 32'h0 || RegwriteW !== 1'b0 || timeout_err !== 1'b1) begin
      errs++;
      $display("FAIL to_sticky: rd=%h Rw=%b to=%b required 0 0 1", ReadDataW, RegwriteW, timeout_err);
    end
    clearM();
    step();
  endtask

  task automatic test_reset_mid();
    clearM();
    MemReadM = 1'b1; funct3M = 3'b010; ALUResultM = 32'h50; RegwriteM = 1'b1; RdM = 5'd6;
    cache_req_ready = 1'b1;
    #1;
    step();
    cache_req_ready = 1'b0;
    #1;
    vecs++;
    if (stall_m !== 1'b1) begin
      errs++;
      $display("FAIL rmid_wait: stall=%b required 1", stall_m);
    end
    rst = 1'b0;
    #1;
    vecs++;
    if ({stall_m, cache_req_valid} !== 2'b00) begin
      errs++;
      $display("FAIL rmid_forced: stall/valid=%b required 00", {stall_m, cache_req_valid});
    end
    step();
    vecs++;
    if ({RegwriteW, RdW, ALUResultW, timeout_err} !== '0) begin
      errs++;
      $display("FAIL rmid_clear: Rw=%b Rd=%0d alu=%h to=%b required all 0", RegwriteW, RdW, ALUResultW, timeout_err);
    end
    rst = 1'b1;
    cache_resp_valid = 1'b1;  // stale response from the abandoned transaction
    #1;
    vecs++;
    if ({cache_req_valid, stall_m} !== 2'b11) begin
      errs++;
      $display("FAIL rmid_idle_reissue: valid/stall=%b required 11", {cache_req_valid, stall_m});
    end
    step();
    vecs++;
    if (RegwriteW !== 1'b0 || ReadDataW !== 32'h0) begin
      errs++;
      $display("FAIL rmid_stale_resp: Rw=%b rd=%h required 0 0", RegwriteW, ReadDataW);
    end
    clearM();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lb();
    test_sh();
    test_misalign();
    test_lhu_slow();
    test_load_format();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
